// File: rtl/cla12_subtractor.sv
// 12-bit subtractor D = A - B - Bin built from three 4-bit carry-lookahead groups.
// Two-stage pipeline with clock enable; group 0 resolves in stage 1, groups 1/2 in stage 2.
module cla12_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        CE,
  input  logic        in_valid,
  input  logic [11:0] A,
  input  logic [11:0] B,
  input  logic        Bin,
  output logic [11:0] D,
  output logic        Bout,
  output logic        out_valid,
  output logic        zero,
  output logic        ovf
);

  function automatic logic [3:0] cla4_sum(input logic [3:0] p, input logic [3:0] g,
                                          input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return p ^ c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Subtraction as A + ~B + ~Bin: propagate/generate use the inverted subtrahend.
  logic [11:0] w_p;
  logic [11:0] w_g;
  logic        w_cin;
  logic        w_c4;
  logic [3:0]  w_s0;

  assign w_cin = ~Bin;
  assign w_p   = A ^ ~B;
  assign w_g   = A & ~B;
  assign w_s0  = cla4_sum(w_p[3:0], w_g[3:0], w_cin);
  assign w_c4  = grp_gen(w_p[3:0], w_g[3:0]) | ((&w_p[3:0]) & w_cin);

  logic [3:0] r_s0;
  logic       r_c4;
  logic [7:0] r_p;
  logic [7:0] r_g;
  logic       r_a11;
  logic       r_b11;
  logic       r_vld1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0   <= '0;
      r_c4   <= 1'b0;
      r_p    <= '0;
      r_g    <= '0;
      r_a11  <= 1'b0;
      r_b11  <= 1'b0;
      r_vld1 <= 1'b0;
    end else if (CE) begin
      r_s0   <= w_s0;
      r_c4   <= w_c4;
      r_p    <= w_p[11:4];
      r_g    <= w_g[11:4];
      r_a11  <= A[11];
      r_b11  <= B[11];
      r_vld1 <= in_valid;
    end
  end

  // Group carries come straight from the lookahead terms, not from chaining group sums.
  logic        w_gg1;
  logic        w_pg1;
  logic        w_gg2;
  logic        w_pg2;
  logic        w_c8;
  logic        w_c12;
  logic [11:0] w_d;

  assign w_gg1 = grp_gen(r_p[3:0], r_g[3:0]);
  assign w_pg1 = &r_p[3:0];
  assign w_gg2 = grp_gen(r_p[7:4], r_g[7:4]);
  assign w_pg2 = &r_p[7:4];
  assign w_c8  = w_gg1 | (w_pg1 & r_c4);
  assign w_c12 = w_gg2 | (w_pg2 & w_gg1) | (w_pg2 & w_pg1 & r_c4);
  assign w_d   = {cla4_sum(r_p[7:4], r_g[7:4], w_c8),
                  cla4_sum(r_p[3:0], r_g[3:0], r_c4),
                  r_s0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D         <= '0;
      Bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (CE) begin
      D         <= w_d;
      Bout      <= ~w_c12;
      zero      <= (w_d == 12'd0);
      ovf       <= (r_a11 != r_b11) && (w_d[11] != r_a11);
      out_valid <= r_vld1;
    end
  end

endmodule

// File: tb/tb_cla12_subtractor.sv
// Scoreboard bench for cla12_subtractor: expected results are queued at issue
// and compared when out_valid appears on a CE-enabled edge.
module tb_cla12_subtractor;

  logic        clk;
  logic        rst;
  logic        CE;
  logic        in_valid;
  logic [11:0] A;
  logic [11:0] B;
  logic        Bin;
  logic [11:0] D;
  logic        Bout;
  logic        out_valid;
  logic        zero;
  logic        ovf;

  cla12_subtractor dut (
    .clk(clk), .rst(rst), .CE(CE), .in_valid(in_valid),
    .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .out_valid(out_valid), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    logic [11:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ce_edges = 0;
  logic edge_ce;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [11:0] a, input logic [11:0] b, input logic bin);
    exp_t e;
    int   diff;
    logic [31:0] dv;
    diff   = int'(a) - int'(b) - int'(bin);
    dv     = diff;
    e.d    = dv[11:0];
    e.bout = (int'(a) < int'(b) + int'(bin));
    e.zero = (e.d == 12'd0);
    e.ovf  = (a[11] != b[11]) && (e.d[11] != a[11]);
    e.due  = 0;
    return e;
  endfunction

  // Monitor: count CE-enabled edges and check results produced on them.
  always begin
    @(posedge clk);
    edge_ce = CE && !rst;
    if (edge_ce) ce_edges++;
    @(negedge clk);
    if (edge_ce && !rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_edge", 32'(ce_edges), 32'(e.due));
        chk("D", 32'(D), 32'(e.d));
        chk("Bout", 32'(Bout), 32'(e.bout));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic op(input logic [11:0] a, input logic [11:0] b, input logic bin);
    exp_t e;
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    e = model(a, b, bin);
    e.due = ce_edges + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [11:0] d_hold;
  logic        v_hold;
  logic        bo_hold;

  initial begin
    rst = 1'b1; CE = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Directed single operations and boundaries.
    op(12'd4, 12'd2, 1'b1);       idle(3);
    op(12'd2, 12'd9, 1'b0);       idle(3);
    op(12'd0, 12'd0, 1'b1);       idle(3);
    op(12'h800, 12'd1, 1'b0);     idle(3);
    op(12'd9, 12'd9, 1'b0);       idle(3);
    op(12'hFFF, 12'hFFF, 1'b1);   idle(3);
    op(12'h7FF, 12'hFFF, 1'b0);   idle(3);
    op(12'hFFF, 12'd0, 1'b0);     idle(3);

    // Back-to-back stream.
    op(12'd4, 12'd2, 1'b1);
    op(12'd999, 12'd2550, 1'b0);
    op(12'd9, 12'd9, 1'b0);
    idle(4);

    // CE stall after the operation has entered stage 1.
    op(12'd100, 12'd37, 1'b1);
    CE = 1'b0;
    d_hold = D; v_hold = out_valid; bo_hold = Bout;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_D_hold", 32'(D), 32'(d_hold));
      chk("stall_vld_hold", 32'(out_valid), 32'(v_hold));
      chk("stall_Bout_hold", 32'(Bout), 32'(bo_hold));
    end
    CE = 1'b1;
    idle(3);

    // Reset mid-flight discards the in-flight operation.
    op(12'd5, 12'd3, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_D", 32'(D), 32'd0);
    chk("midrst_Bout", 32'(Bout), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_vld", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Random operations with occasional bubbles.
    for (int i = 0; i < 40; i++) begin
      op(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(5);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
